// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator with framebuffer fetch and LAT-cycle data alignment.
// Optional colour-bar source selected by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned LAT      = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic [9:0]  PIX_X,
  output logic [9:0]  PIX_Y,
  output logic        FETCH,
  input  logic [23:0] PIX_DATA,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        FRAME_START
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic       active;
    logic       hs;
    logic       vs;
    logic       first;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } flags_t;

  logic [9:0] hc;
  logic [9:0] vc;
  logic       active;
  flags_t     cur;
  flags_t     dly [LAT];
  logic [23:0] src_rgb;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hc <= '0;
      vc <= '0;
    end else if (EN) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  assign active = (hc < H_ACT) && (vc < V_ACT);
  assign FETCH  = active;
  assign PIX_X  = active ? hc : '0;
  assign PIX_Y  = active ? vc : '0;

  always_comb begin
    cur        = '0;
    cur.active = active;
    cur.hs     = (hc >= HS_START) && (hc < HS_END);
    cur.vs     = (vc >= VS_START) && (vc < VS_END);
    cur.first  = (hc == '0) && (vc == '0);
`ifdef VGA_TEST_PATTERN_EN
    cur.bar    = 3'(hc / 10'(H_ACTIVE / 8));
`endif
  end

  // Flags travel alongside the framebuffer read so they meet PIX_DATA at the output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < LAT; i++) dly[i] <= '0;
    end else if (EN) begin
      dly[0] <= cur;
      for (int unsigned i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic unused_pix;
  assign unused_pix = ^PIX_DATA;

  always_comb begin
    src_rgb = 24'h000000;
    case (dly[LAT-1].bar)
      3'd0: src_rgb = 24'hFFFFFF;
      3'd1: src_rgb = 24'hFFFF00;
      3'd2: src_rgb = 24'h00FFFF;
      3'd3: src_rgb = 24'h00FF00;
      3'd4: src_rgb = 24'hFF00FF;
      3'd5: src_rgb = 24'hFF0000;
      3'd6: src_rgb = 24'h0000FF;
      default: src_rgb = 24'h000000;
    endcase
  end
`else
  assign src_rgb = PIX_DATA;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      FRAME_START <= 1'b0;
    end else if (EN) begin
      {VGA_R, VGA_G, VGA_B} <= dly[LAT-1].active ? src_rgb : '0;
      VGA_BLANK_N <= dly[LAT-1].active;
      VGA_HS      <= dly[LAT-1].hs ? HS_POL : ~HS_POL;
      VGA_VS      <= dly[LAT-1].vs ? VS_POL : ~VS_POL;
      FRAME_START <= dly[LAT-1].first;
    end
  end

  assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster; outputs are predicted from
// the count of enabled clock edges since reset.
module tb_vga_timing_gen;

  localparam int HA = 64, HF = 4, HSW = 8, HB = 4;
  localparam int VA = 12, VF = 2, VSW = 2, VB = 3;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [9:0]  pix_x, pix_y;
  logic        fetch;
  logic [23:0] pix_data;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .LAT(LAT)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en),
    .PIX_X(pix_x), .PIX_Y(pix_y), .FETCH(fetch), .PIX_DATA(pix_data),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
    .VGA_SYNC_N(vga_sync_n), .FRAME_START(frame_start)
  );

  // Framebuffer: returns {x[7:0], y[7:0], A5} LAT enabled edges after the fetch, stalling with EN.
  logic [19:0] mem [LAT];
  always @(posedge clk) begin
    if (en) begin
      mem[0] <= {pix_x, pix_y};
      for (int i = 1; i < LAT; i++) mem[i] <= mem[i-1];
    end
  end
  assign pix_data = {mem[LAT-1][17:10], mem[LAT-1][7:0], 8'hA5};

`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (n=%0d t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  task automatic check_all();
    int x, y, pos;
    logic act;
    logic [23:0] e_rgb;
    logic e_blank, e_hs, e_vs, e_fs;
    // fetch side: current position is n
    x = n % HT;
    y = (n / HT) % VT;
    act = (x < HA) && (y < VA);
    check("fetch", 32'(fetch), 32'(act));
    check("pix_xy", {12'd0, pix_x, pix_y}, act ? {12'd0, 10'(x), 10'(y)} : 32'd0);
    // output side: position LAT+1 enabled edges earlier
    pos = n - (LAT + 1);
    if (pos < 0) begin
      e_rgb = '0; e_blank = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    end else begin
      x = pos % HT;
      y = (pos / HT) % VT;
      e_blank = (x < HA) && (y < VA);
`ifdef VGA_TEST_PATTERN_EN
      e_rgb = e_blank ? bars[x / (HA / 8)] : 24'd0;
`else
      e_rgb = e_blank ? {8'(x), 8'(y), 8'hA5} : 24'd0;
`endif
      e_hs = !((x >= HA + HF) && (x < HA + HF + HSW));
      e_vs = !((y >= VA + VF) && (y < VA + VF + VSW));
      e_fs = (pos % (HT * VT)) == 0;
    end
    check("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, e_rgb});
    check("blank_n", 32'(vga_blank_n), 32'(e_blank));
    check("hsync", 32'(vga_hs), 32'(e_hs));
    check("vsync", 32'(vga_vs), 32'(e_vs));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("sync_n", 32'(vga_sync_n), 32'd0);
  endtask

  task automatic step(input logic r_in, input logic e_in);
    rst = r_in;
    en  = e_in;
    @(posedge clk);
    if (r_in) n = 0;
    else if (e_in) n++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int stall;
    stall = 0;
    // reset held three cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    // run into line 2, then a 50-cycle stall mid-line
    while (n < 2 * HT + 20) step(1'b0, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
    // RST wins over EN
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    // randomized enable bursts and occasional mid-frame resets
    for (int i = 0; i < 12000; i++) begin
      if (stall == 0 && $urandom_range(0, 19) == 0) stall = $urandom_range(1, 60);
      if ($urandom_range(0, 3999) == 0) step(1'b1, 1'($urandom_range(0, 1)));
      else if (stall > 0) begin
        stall--;
        step(1'b0, 1'b0);
      end else begin
        step(1'b0, 1'($urandom_range(0, 15) != 0));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
